ram_arbiter: RTL and testbench

- Shares the single-port, word-addressed 32-bit RAM between two requesters of the core: instruction fetch (IF) and load/store (D).
- Arbitrates round-robin and sequences each access through the RAM's one-cycle synchronous read.
- Returns read data and completion strobes to the winning requester.
- Sits between the fetch/LSU stages and the RAM instance; it is the only block that drives the RAM's address, write and data inputs.

---
 rtl/ram_arb_pkg.sv | 22 ++
 rtl/rr_arb2.sv | 38 +++
 rtl/ram_arbiter.sv | 128 ++++++++++++
 tb/tb_ram_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the RAM arbiter and its round-robin helper.
package ram_arb_pkg;

  localparam int ADDR_W_DEF = 10;
  localparam int DATA_W_DEF = 32;

  // Requester ids; also the bit index of each requester in req/gnt vectors.
  localparam logic REQ_IF = 1'b0;
  localparam logic REQ_D  = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  // True when any address bit above the implemented RAM depth is set.
  function automatic logic addr_oor(input logic [31:0] addr, input int addr_w);
    return (addr >> addr_w) != 32'd0;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter. Grant is combinational; the last winner is
// remembered so that a simultaneous request goes to the other requester.
module rr_arb2
  import ram_arb_pkg::*;
(
  input  logic       clk,
  input  logic       clr_n,
  input  logic [1:0] req,
  input  logic       enable,
  output logic [1:0] gnt
);

  logic last_grant;

  // One-hot grant: a lone request wins outright, a conflict goes to the
  // requester that did not win last time.
  always_comb begin
    gnt = 2'b00;
    if (enable) begin
      if (req == 2'b11) begin
        gnt = (last_grant == REQ_D) ? 2'b01 : 2'b10;
      end else begin
        gnt = req;
      end
    end
  end

  // Remember the winner of every accepted grant; D is "last" out of reset so
  // IF takes the first conflict.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      last_grant <= REQ_D;
    end else if (enable && |gnt) begin
      last_grant <= gnt[1];
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Shares the single-port synchronous RAM between instruction fetch (IF) and
// load/store (D). Each access takes an accept cycle, an ISSUE cycle where the
// RAM samples address/write, and a RESP cycle where the read data is returned.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no access in flight; may accept
// ISSUE | RAM sampling the registered address / write strobe
// RESP  | RAM data valid, owner's rvalid pulses; may accept the next access
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              clr_n,

  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic              if_ready,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_err,

  input  logic              d_req,
  input  logic              d_we,
  input  logic [31:0]       d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ready,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_err,

  output logic [31:0]       ram_addr,
  output logic              ram_write,
  output logic [DATA_W-1:0] ram_datain,
  input  logic [DATA_W-1:0] ram_dataout
);

  state_t      state;
  logic        owner;
  logic        owner_we;
  logic        owner_err;

  logic        accept_en;
  logic        accept;
  logic [1:0]  gnt;
  logic [31:0] sel_addr;
  logic        sel_we;
  logic        sel_oor;
  logic        resp;

  assign accept_en = (state == IDLE) || (state == RESP);

  rr_arb2 u_arb (
    .clk    (clk),
    .clr_n  (clr_n),
    .req    ({d_req, if_req}),
    .enable (accept_en),
    .gnt    (gnt)
  );

  assign if_ready = gnt[REQ_IF];
  assign d_ready  = gnt[REQ_D];
  assign accept   = |gnt;

  // IF never writes, so only a D grant can carry a write.
  assign sel_addr = gnt[REQ_D] ? d_addr : if_addr;
  assign sel_we   = gnt[REQ_D] & d_we;
  assign sel_oor  = addr_oor(sel_addr, ADDR_W);

  // Sequence each access accept -> ISSUE -> RESP; RESP may chain a new accept.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    if (accept) state <= ISSUE;
        ISSUE:   state <= RESP;
        RESP:    state <= accept ? ISSUE : IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Capture the winning access; the write strobe lives for the ISSUE cycle only
  // and is suppressed for out-of-range addresses.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      ram_addr   <= 32'd0;
      ram_datain <= '0;
      ram_write  <= 1'b0;
      owner      <= REQ_IF;
      owner_we   <= 1'b0;
      owner_err  <= 1'b0;
    end else if (accept) begin
      ram_addr   <= sel_addr;
      ram_datain <= gnt[REQ_D] ? d_wdata : '0;
      ram_write  <= sel_we && !sel_oor;
      owner      <= gnt[REQ_D];
      owner_we   <= sel_we;
      owner_err  <= sel_oor;
    end else begin
      ram_write  <= 1'b0;
    end
  end

  assign resp = (state == RESP);

  // Route the completion to the owner; data is forced to zero for writes,
  // errors and every non-RESP cycle so nothing stale leaks out.
  always_comb begin
    if_rvalid = resp && (owner == REQ_IF);
    d_rvalid  = resp && (owner == REQ_D);
    if_err    = if_rvalid && owner_err;
    d_err     = d_rvalid && owner_err;
    if_rdata  = '0;
    d_rdata   = '0;
    if (if_rvalid && !owner_err) begin
      if_rdata = ram_dataout;
    end
    if (d_rvalid && !owner_err && !owner_we) begin
      d_rdata = ram_dataout;
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: a behavioural RAM, a cycle-level model of the
// arbitration/latency rules checked every cycle, and directed scenarios with
// literal expectations.
module tb_ram_arbiter;

  logic        clk = 1'b0;
  logic        clr_n = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = 32'd0;
  logic        if_ready, if_rvalid, if_err;
  logic [31:0] if_rdata;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [31:0] d_addr = 32'd0;
  logic [31:0] d_wdata = 32'd0;
  logic        d_ready, d_rvalid, d_err;
  logic [31:0] d_rdata;
  logic [31:0] ram_addr;
  logic        ram_write;
  logic [31:0] ram_datain;
  logic [31:0] ram_dataout;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  ram_arbiter dut (
    .clk         (clk),
    .clr_n       (clr_n),
    .if_req      (if_req),
    .if_addr     (if_addr),
    .if_ready    (if_ready),
    .if_rvalid   (if_rvalid),
    .if_rdata    (if_rdata),
    .if_err      (if_err),
    .d_req       (d_req),
    .d_we        (d_we),
    .d_addr      (d_addr),
    .d_wdata     (d_wdata),
    .d_ready     (d_ready),
    .d_rvalid    (d_rvalid),
    .d_rdata     (d_rdata),
    .d_err       (d_err),
    .ram_addr    (ram_addr),
    .ram_write   (ram_write),
    .ram_datain  (ram_datain),
    .ram_dataout (ram_dataout)
  );

  function automatic logic [31:0] init_val(input int i);
    if (i == 5) return 32'hDEADBEEF;
    return 32'h1000_0000 | i;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // Synchronous single-port RAM, 1024 words, read-before-write.
  logic [31:0] mem [0:1023];
  logic        mem_loaded = 1'b0;
  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < 1024; i++) mem[i] <= init_val(i);
      mem_loaded <= 1'b1;
    end else begin
      if (ram_write) mem[ram_addr[9:0]] <= ram_datain;
      ram_dataout <= mem[ram_addr[9:0]];
    end
  end

  // ---------------- behavioural model + per-cycle compare ----------------
  int          cyc = 0;
  bit          m_loaded = 0;
  logic [31:0] exp_mem [0:1023];
  bit          m_last = 1;
  int          m_nf = 0;
  bit          pv = 0;
  int          pcyc;
  bit          pwho;
  bit          perr;
  logic [31:0] pdata;
  bit          wv = 0;
  int          wcyc;
  logic [9:0]  waddr;
  logic [31:0] wdat;
  bit          av = 0;
  int          acyc;
  logic [31:0] aaddr;

  always @(negedge clk) begin
    bit          now, e_ifv, e_dv, e_err, e_wr, can, win, e_ifr, e_dr, a_oor;
    logic [31:0] e_rd, a_addr;
    if (!m_loaded) begin
      for (int i = 0; i < 1024; i++) exp_mem[i] = init_val(i);
      m_loaded = 1;
    end
    if (!clr_n) begin
      chk("rst_ram_write", ram_write, 0);
      chk("rst_if_rvalid", if_rvalid, 0);
      chk("rst_d_rvalid", d_rvalid, 0);
      chk("rst_if_rdata", if_rdata, 0);
      chk("rst_d_rdata", d_rdata, 0);
      pv = 0; wv = 0; av = 0; m_last = 1; m_nf = 0;
    end else begin
      now   = pv && (pcyc == cyc);
      e_ifv = now && (pwho == 0);
      e_dv  = now && (pwho == 1);
      e_err = now && perr;
      e_rd  = now ? pdata : 32'd0;
      chk("m_if_rvalid", if_rvalid, e_ifv);
      chk("m_if_err", if_err, e_ifv && e_err);
      chk("m_if_rdata", if_rdata, e_ifv ? e_rd : 32'd0);
      chk("m_d_rvalid", d_rvalid, e_dv);
      chk("m_d_err", d_err, e_dv && e_err);
      chk("m_d_rdata", d_rdata, e_dv ? e_rd : 32'd0);
      e_wr = wv && (wcyc == cyc);
      chk("m_ram_write", ram_write, e_wr);
      if (e_wr) chk("m_ram_datain", ram_datain, wdat);
      if (av && (acyc == cyc)) chk("m_ram_addr", ram_addr, aaddr);
      can = (cyc >= m_nf);
      win = (if_req && d_req) ? ~m_last : d_req;
      e_ifr = can && if_req && !win;
      e_dr  = can && d_req && win;
      chk("m_if_ready", if_ready, e_ifr);
      chk("m_d_ready", d_ready, e_dr);
      if (e_wr) begin
        exp_mem[waddr] = wdat;
        wv = 0;
      end
      if (now) pv = 0;
      if (e_ifr || e_dr) begin
        a_addr = win ? d_addr : if_addr;
        a_oor  = (a_addr[31:10] != 22'd0);
        pv = 1; pcyc = cyc + 2; pwho = win; perr = a_oor;
        pdata = (a_oor || (win && d_we)) ? 32'd0 : exp_mem[a_addr[9:0]];
        if (win && d_we && !a_oor) begin
          wv = 1; wcyc = cyc + 1; waddr = a_addr[9:0]; wdat = d_wdata;
        end
        av = 1; acyc = cyc + 1; aaddr = a_addr;
        m_last = win;
        m_nf = cyc + 2;
      end
    end
    cyc++;
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_ready(input bit is_d, output int k);
    k = 0;
    while (k < 20) begin
      @(negedge clk);
      if (is_d ? d_ready : if_ready) break;
      k++;
    end
    if (k == 20) chk(is_d ? "d_ready_timeout" : "if_ready_timeout", 0, 1);
  endtask

  task automatic do_if(input string nm, input logic [31:0] a, input logic [31:0] exp_d,
                       input bit exp_e);
    int k;
    @(posedge clk); #1;
    if_req = 1; if_addr = a;
    wait_ready(0, k);
    chk({nm, "_wait"}, k, 0);
    @(posedge clk); #1;
    if_req = 0;
    @(negedge clk);
    chk({nm, "_early_rvalid"}, if_rvalid, 0);
    @(negedge clk);
    chk({nm, "_rvalid"}, if_rvalid, 1);
    chk({nm, "_rdata"}, if_rdata, exp_d);
    chk({nm, "_err"}, if_err, exp_e);
  endtask

  task automatic do_d(input string nm, input bit we, input logic [31:0] a,
                      input logic [31:0] wd, input logic [31:0] exp_d, input bit exp_e);
    int k;
    @(posedge clk); #1;
    d_req = 1; d_we = we; d_addr = a; d_wdata = wd;
    wait_ready(1, k);
    chk({nm, "_wait"}, k, 0);
    @(posedge clk); #1;
    d_req = 0;
    chk({nm, "_wr_issue"}, ram_write, (we && !exp_e) ? 1 : 0);
    @(negedge clk);
    chk({nm, "_early_rvalid"}, d_rvalid, 0);
    @(posedge clk); #1;
    chk({nm, "_wr_cleared"}, ram_write, 0);
    @(negedge clk);
    chk({nm, "_rvalid"}, d_rvalid, 1);
    chk({nm, "_rdata"}, d_rdata, exp_d);
    chk({nm, "_err"}, d_err, exp_e);
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    int n;
    int k;
    bit seen;
    bit ord [8];
    int at [8];

    #1;
    chk("reset_ram_addr", ram_addr, 0);
    chk("reset_ram_datain", ram_datain, 0);
    chk("reset_ram_write", ram_write, 0);
    repeat (2) @(posedge clk);
    #2 clr_n = 1;

    // Single IF read.
    do_if("if_rd5", 32'd5, 32'hDEADBEEF, 0);

    // D write then read back.
    do_d("d_wr7", 1, 32'd7, 32'h12345678, 32'd0, 0);
    do_d("d_rd7", 0, 32'd7, 32'd0, 32'h12345678, 0);

    // Continuous conflict: last grant is D, so IF leads and they alternate.
    n = 0; k = 0;
    @(posedge clk); #1;
    if_req = 1; if_addr = 32'd5;
    d_req = 1; d_we = 0; d_addr = 32'd7;
    while (n < 8 && k < 40) begin
      @(negedge clk);
      k++;
      if (if_ready || d_ready) begin
        ord[n] = d_ready;
        at[n] = k;
        n++;
      end
    end
    @(posedge clk); #1;
    if_req = 0; d_req = 0;
    chk("arb_accepts", n, 8);
    for (int i = 0; i < n; i++) chk("arb_order", ord[i], i % 2);
    for (int i = 1; i < n; i++) chk("arb_spacing", at[i] - at[i-1], 2);
    repeat (3) @(negedge clk);

    // Out-of-range write is suppressed; word 0 (alias of 0x400) untouched.
    do_d("d_wr_oor", 1, 32'h0000_0400, 32'hCAFEF00D, 32'd0, 1);
    do_d("d_rd0", 0, 32'd0, 32'd0, 32'h1000_0000, 0);
    do_if("if_rd_oor", 32'h8000_0003, 32'd0, 1);

    // Reset during ISSUE of a D write.
    @(posedge clk); #1;
    d_req = 1; d_we = 1; d_addr = 32'd9; d_wdata = 32'hAAAA5555;
    wait_ready(1, k);
    @(posedge clk); #1;
    d_req = 0;
    chk("rst_mid_wr_before", ram_write, 1);
    #2 clr_n = 0;
    #1;
    chk("rst_mid_wr_after", ram_write, 0);
    repeat (2) @(posedge clk);
    #2 clr_n = 1;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (d_rvalid) seen = 1;
    end
    chk("rst_no_d_rvalid", seen, 0);
    @(posedge clk); #1;
    if_req = 1; if_addr = 32'd9;
    d_req = 1; d_we = 0; d_addr = 32'd5;
    @(negedge clk);
    chk("rst_first_if_ready", if_ready, 1);
    chk("rst_first_d_ready", d_ready, 0);
    @(posedge clk); #1;
    if_req = 0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_mem9_kept", if_rdata, 32'h1000_0009);
    chk("rst_d_ready_resp", d_ready, 1);
    @(posedge clk); #1;
    d_req = 0;
    repeat (3) @(negedge clk);

    // Back-to-back: IF accepted in the RESP cycle of a D read.
    @(posedge clk); #1;
    d_req = 1; d_we = 0; d_addr = 32'd7;
    wait_ready(1, k);
    @(posedge clk); #1;
    d_req = 0;
    if_req = 1; if_addr = 32'd5;
    @(negedge clk);
    chk("b2b_issue_if_ready", if_ready, 0);
    @(negedge clk);
    chk("b2b_d_rvalid", d_rvalid, 1);
    chk("b2b_d_rdata", d_rdata, 32'h12345678);
    chk("b2b_if_ready", if_ready, 1);
    @(posedge clk); #1;
    if_req = 0;
    @(negedge clk);
    @(negedge clk);
    chk("b2b_if_rvalid", if_rvalid, 1);
    chk("b2b_if_rdata", if_rdata, 32'hDEADBEEF);
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
